// File: rtl/widemem_burst_arbiter.sv
// Two-requester round-robin burst arbiter/sequencer for the 64-bit wide memory port.
// Issues len+1 beats per burst; read data returns one cycle after each issued beat.
module widemem_burst_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*LEN_W-1:0]    req_len,
   input  logic [2*DATA_W-1:0]   wdata,
   input  logic [1:0]            wvalid,
   output logic [1:0]            wready,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            rvalid,
   output logic                  busy,
   output logic                  mem_en,
   output logic [1:0]            mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t              state, state_nxt;
   logic                gnt, gnt_nxt;
   logic                last, last_nxt;
   logic [ADDR_W-1:0]   cur, cur_nxt;
   logic [LEN_W-1:0]    cnt, cnt_nxt;
   logic [1:0]          rv_q, rv_nxt;
   logic                pick;

   // On a tie the requester not granted last wins; otherwise the lone requester.
   always_comb begin
      if (req_valid == 2'b11) pick = ~last;
      else                    pick = req_valid[1];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
         cur   <= '0;
         cnt   <= '0;
         rv_q  <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
         cur   <= cur_nxt;
         cnt   <= cnt_nxt;
         rv_q  <= rv_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      cur_nxt   = cur;
      cnt_nxt   = cnt;
      rv_nxt    = '0;
      req_ready = '0;
      wready    = '0;
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            // rstn gating keeps the accept pulse quiet while reset is held
            if ((|req_valid) && rstn) begin
               req_ready[pick] = 1'b1;
               gnt_nxt         = pick;
               last_nxt        = pick;
               cur_nxt         = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
               cnt_nxt         = pick ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
               state_nxt       = req_we[pick] ? WRITE : READ;
            end
         end
         WRITE: begin
            wready[gnt] = 1'b1;
            if (wvalid[gnt]) begin
               mem_en    = 1'b1;
               mem_we    = '1;
               mem_wdata = gnt ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
               cur_nxt   = cur + ADDR_W'(1);
               cnt_nxt   = cnt - LEN_W'(1);
               if (cnt == '0) state_nxt = IDLE;
            end
         end
         READ: begin
            mem_en      = 1'b1;
            rv_nxt[gnt] = 1'b1;
            cur_nxt     = cur + ADDR_W'(1);
            cnt_nxt     = cnt - LEN_W'(1);
            if (cnt == '0) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_addr = cur;
   assign rvalid   = rv_q;
   assign rdata    = (|rv_q) ? mem_rdata : '0;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_widemem_burst_arbiter.sv
// Self-checking bench for widemem_burst_arbiter: directed and random bursts against
// a memory-image reference model and a round-robin grant model.
module tb_widemem_burst_arbiter;
   localparam int AW = 11;
   localparam int DW = 64;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [1:0]      req_valid, req_ready, req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*LW-1:0] req_len;
   logic [2*DW-1:0] wdata;
   logic [1:0]      wvalid, wready, rvalid;
   logic [DW-1:0]   rdata;
   logic            busy, mem_en;
   logic [1:0]      mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int last_g = 1;

   logic [DW-1:0] ref_mem [2048];
   logic [DW-1:0] mem [2048];
   bit            written [2048];

   always #5 clk = ~clk;

   widemem_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .wdata(wdata),
      .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid),
      .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory behind the wide port: unwritten words read back their own address.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 2'b11) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : DW'(mem_addr);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh(input int g);
      logic [1:0] one = 2'b01;
      return one << g;
   endfunction

   // Round-robin reference: a lone requester wins, a tie goes to the one not granted last.
   function automatic int pick_model(input logic [1:0] m);
      int g;
      if (m == 2'b11) g = 1 - last_g;
      else            g = m[1] ? 1 : 0;
      last_g = g;
      return g;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int r, input logic [AW-1:0] a, input int len);
      int g;
      logic [AW-1:0] ea;
      req_valid[r] = 1'b1;
      req_we[r] = 1'b0;
      req_addr[r*AW +: AW] = a;
      req_len[r*LW +: LW] = LW'(len);
      #1;
      g = pick_model(req_valid);
      check("rd_ready", req_ready, oh(g));
      cyc();
      req_valid[r] = 1'b0;
      for (int i = 0; i <= len; i++) begin
         #1;
         ea = a + AW'(i);
         check("rd_mem_en", mem_en, 1);
         check("rd_mem_we", mem_we, 0);
         check("rd_mem_addr", mem_addr, ea);
         check("rd_busy", busy, 1);
         if (i == 0) check("rd_rvalid_first", rvalid, 0);
         else begin
            check("rd_rvalid", rvalid, oh(g));
            check("rd_rdata", rdata, ref_mem[ea - AW'(1)]);
         end
         cyc();
      end
      #1;
      ea = a + AW'(len);
      check("drain_rvalid", rvalid, oh(g));
      check("drain_rdata", rdata, ref_mem[ea]);
      check("drain_mem_en", mem_en, 0);
      check("drain_busy", busy, 1);
      cyc();
      #1;
      check("rd_end_busy", busy, 0);
      check("rd_end_rvalid", rvalid, 0);
      check("rd_end_mem_en", mem_en, 0);
   endtask

   task automatic do_write(input int r, input logic [AW-1:0] a, input int len,
                           input logic [63:0] pat, input int late_r,
                           input logic [AW-1:0] late_a, input int late_len);
      int g;
      int beats;
      int i;
      logic v;
      logic [DW-1:0] d;
      logic [AW-1:0] ea;
      req_valid[r] = 1'b1;
      req_we[r] = 1'b1;
      req_addr[r*AW +: AW] = a;
      req_len[r*LW +: LW] = LW'(len);
      #1;
      g = pick_model(req_valid);
      check("wr_ready", req_ready, oh(g));
      cyc();
      req_valid[r] = 1'b0;
      beats = 0;
      i = 0;
      while (beats <= len && i < 200) begin
         v = (i < 64) ? pat[i] : 1'b1;
         d = {$urandom, $urandom};
         wvalid[g] = v;
         wdata[g*DW +: DW] = d;
         if (i == 2 && late_r >= 0) begin
            req_valid[late_r] = 1'b1;
            req_we[late_r] = 1'b0;
            req_addr[late_r*AW +: AW] = late_a;
            req_len[late_r*LW +: LW] = LW'(late_len);
         end
         #1;
         ea = a + AW'(beats);
         check("wr_wready", wready, oh(g));
         check("wr_no_grant", req_ready, 0);
         check("wr_busy", busy, 1);
         check("wr_mem_en", mem_en, v);
         if (v) begin
            check("wr_mem_we", mem_we, 2'b11);
            check("wr_mem_addr", mem_addr, ea);
            check("wr_mem_wdata", mem_wdata, d);
            ref_mem[ea] = d;
            beats++;
         end else begin
            check("wr_stall_we", mem_we, 0);
         end
         i++;
         cyc();
      end
      if (beats <= len) check("wr_beat_budget", beats, len + 1);
      wvalid = '0;
      #1;
      check("wr_end_busy", busy, 0);
      check("wr_end_mem_en", mem_en, 0);
      check("wr_end_wready", wready, 0);
   endtask

   initial begin
      int g;
      logic [AW-1:0] ta;
      for (int k = 0; k < 2048; k++) ref_mem[k] = DW'(k);
      rstn = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
      wdata = '0; wvalid = '0;
      cyc(); cyc();
      check("rst_req_ready", req_ready, 0);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", rdata, 0);
      rstn = 1'b1;
      cyc();

      // Simultaneous requests straight out of reset: requester 0 takes the first tie.
      req_valid = 2'b11;
      req_we = 2'b00;
      req_addr = {11'h100, 11'h080};
      req_len = '0;
      for (int b = 0; b < 3; b++) begin
         #1;
         g = pick_model(2'b11);
         ta = (g == 1) ? 11'h100 : 11'h080;
         check("tie_ready", req_ready, oh(g));
         check("tie_onehot", 64'($countones(req_ready)), 1);
         cyc();
         #1;
         check("tie_mem_addr", mem_addr, ta);
         cyc();
         #1;
         check("tie_rvalid", rvalid, oh(g));
         check("tie_rdata", rdata, ref_mem[ta]);
         cyc();
      end
      req_valid = '0;

      do_read(0, 11'h010, 3);

      // Stalled write that wraps past the top of the address space, then read back.
      do_write(1, 11'h7FE, 3, 64'b101101, -1, '0, 0);
      do_read(1, 11'h7FE, 3);

      // Requester 1 arrives mid-burst and is only granted once the FSM returns to IDLE.
      do_write(0, 11'h300, 7, {$urandom, $urandom}, 1, 11'h300, 7);
      do_read(1, 11'h300, 7);

      do_read(0, 11'h200, 0);
      do_write(0, 11'h200, 0, 64'h1, -1, '0, 0);
      do_read(0, 11'h200, 0);

      for (int k = 0; k < 24; k++) begin
         if ($urandom % 2 == 1)
            do_write(int'($urandom % 2), AW'($urandom), int'($urandom % 16),
                     {$urandom, $urandom}, -1, '0, 0);
         else
            do_read(int'($urandom % 2), AW'($urandom), int'($urandom % 16));
      end

      // Reset in the middle of a 16-beat read.
      req_valid[0] = 1'b1;
      req_we[0] = 1'b0;
      req_addr[AW-1:0] = 11'h3F0;
      req_len[LW-1:0] = 4'd15;
      #1;
      g = pick_model(req_valid);
      check("mid_ready", req_ready, oh(g));
      cyc();
      req_valid[0] = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      #2;
      rstn = 1'b0;
      last_g = 1;
      #1;
      check("mid_rst_mem_en", mem_en, 0);
      check("mid_rst_mem_we", mem_we, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_mem_addr", mem_addr, 0);
      check("mid_rst_wready", wready, 0);
      check("mid_rst_req_ready", req_ready, 0);
      cyc(); cyc();
      #3;
      rstn = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("post_rst_rvalid", rvalid, 0);
         check("post_rst_mem_en", mem_en, 0);
         cyc();
      end
      do_read(0, 11'h055, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
